// File: rtl/mem_ctrl.sv
// Byte-serial controller for a single-port RAM shared by instruction fetch and load/store.
// Loads take priority over fetches, and a branch flush can abort a fetch that is in flight.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_len,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_addr,
    output logic        ram_wr
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
    typedef enum logic {OWN_IF, OWN_MEM} owner_t;

    state_t      state, state_next;
    owner_t      owner, owner_next;
    logic        we, we_next;
    logic [31:0] base, base_next;
    logic [31:0] buffer, buffer_next;
    logic [31:0] wdata, wdata_next;
    logic [2:0]  n, n_next;
    logic [2:0]  i, i_next;
    logic [2:0]  j, j_next;
    logic [31:0] if_data_q, mem_rdata_q;
    logic [2:0]  mem_n;

    // A length code of 10 is treated the same as a full word
    always_comb begin
        case (mem_len)
            2'b00:   mem_n = 3'd1;
            2'b01:   mem_n = 3'd2;
            default: mem_n = 3'd4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= OWN_IF;
            we          <= 1'b0;
            base        <= 32'd0;
            buffer      <= 32'd0;
            wdata       <= 32'd0;
            n           <= 3'd0;
            i           <= 3'd0;
            j           <= 3'd0;
            if_data_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
        end else begin
            state  <= state_next;
            owner  <= owner_next;
            we     <= we_next;
            base   <= base_next;
            buffer <= buffer_next;
            wdata  <= wdata_next;
            n      <= n_next;
            i      <= i_next;
            j      <= j_next;
            // Response registers keep the last delivered value between done pulses
            if (state == DONE && owner == OWN_IF)
                if_data_q <= buffer;
            if (state == DONE && owner == OWN_MEM && !we)
                mem_rdata_q <= buffer;
        end
    end

    always_comb begin
        state_next  = state;
        owner_next  = owner;
        we_next     = we;
        base_next   = base;
        buffer_next = buffer;
        wdata_next  = wdata;
        n_next      = n;
        i_next      = i;
        j_next      = j;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    owner_next  = OWN_MEM;
                    we_next     = mem_we;
                    base_next   = mem_addr;
                    wdata_next  = mem_wdata;
                    n_next      = mem_n;
                    buffer_next = 32'd0;
                    i_next      = 3'd0;
                    j_next      = 3'd0;
                    state_next  = mem_we ? WR : RD;
                end else if (if_req) begin
                    owner_next  = OWN_IF;
                    we_next     = 1'b0;
                    base_next   = if_addr;
                    n_next      = 3'd4;
                    buffer_next = 32'd0;
                    i_next      = 3'd0;
                    j_next      = 3'd0;
                    state_next  = RD;
                end
            end
            RD: begin
                if (owner == OWN_IF && if_flush) begin
                    state_next = IDLE;
                end else begin
                    if (i < n)
                        i_next = i + 3'd1;
                    // RAM data lags the address by one cycle, so capture trails issue
                    if (i != j) begin
                        buffer_next[{j[1:0], 3'b000} +: 8] = ram_din;
                        j_next = j + 3'd1;
                        if (j + 3'd1 == n)
                            state_next = DONE;
                    end
                end
            end
            WR: begin
                i_next = i + 3'd1;
                if (i + 3'd1 == n)
                    state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        ram_addr  = 32'd0;
        ram_dout  = 8'd0;
        ram_wr    = 1'b0;
        if_done   = (state == DONE) && (owner == OWN_IF);
        mem_done  = (state == DONE) && (owner == OWN_MEM);
        if_data   = if_done ? buffer : if_data_q;
        mem_rdata = (mem_done && !we) ? buffer : mem_rdata_q;
        if (state == RD && i < n) begin
            ram_addr = base + {29'd0, i};
        end else if (state == WR) begin
            ram_addr = base + {29'd0, i};
            ram_dout = wdata[{i[1:0], 3'b000} +: 8];
            ram_wr   = 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a behavioural byte RAM, per-requester scoreboards,
// and timing checks on the RAM port and on the done pulses.
module tb_mem_ctrl;

    typedef struct {
        bit          is_load;
        logic [31:0] data;
    } mem_exp_t;

    logic        clk, rst;
    logic        if_req, if_flush, if_done;
    logic [31:0] if_addr, if_data;
    logic        mem_req, mem_we, mem_done;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  ram_din, ram_dout;
    logic [31:0] ram_addr;
    logic        ram_wr;

    logic [7:0]  ram [0:4095];
    logic        ram_init;
    int          n_cmp, n_bad;
    logic [31:0] if_q[$];
    mem_exp_t    mem_q[$];

    mem_ctrl dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_data(if_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ram_din(ram_din), .ram_dout(ram_dout),
        .ram_addr(ram_addr), .ram_wr(ram_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM, only the low 12 address bits decoded
    always @(posedge clk) begin
        if (ram_init) begin
            for (int a = 0; a < 4096; a++) ram[a] <= 8'h00;
            ram[12'h100] <= 8'h13; ram[12'h101] <= 8'h05;
            ram[12'h102] <= 8'h10; ram[12'h103] <= 8'h00;
            ram[12'h104] <= 8'h93; ram[12'h105] <= 8'h08;
            ram[12'h106] <= 8'h00; ram[12'h107] <= 8'h00;
            ram[12'h200] <= 8'h34; ram[12'h201] <= 8'hAB;
            ram[12'hFFE] <= 8'h11; ram[12'hFFF] <= 8'h22;
            ram[12'h000] <= 8'h33; ram[12'h001] <= 8'h44;
        end else if (ram_wr) begin
            ram[ram_addr[11:0]] <= ram_dout;
        end
        ram_din <= ram[ram_addr[11:0]];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (if_done) begin
            if (if_q.size() == 0) checkOutput("if_spurious_done", 32'd1, 32'd0);
            else checkOutput("if_data", if_data, if_q.pop_front());
        end
        if (mem_done) begin
            if (mem_q.size() == 0) begin
                checkOutput("mem_spurious_done", 32'd1, 32'd0);
            end else begin
                mem_exp_t e;
                e = mem_q.pop_front();
                if (e.is_load) checkOutput("mem_rdata", mem_rdata, e.data);
            end
        end
    end

    // One isolated access: drives the request, checks each RAM cycle and the done latency
    task automatic applyStimulus(input bit is_if, input bit we, input logic [1:0] len,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp);
        int n, lat, t;
        n   = is_if ? 4 : (len == 2'b00 ? 1 : (len == 2'b01 ? 2 : 4));
        lat = we ? n + 1 : n + 2;
        t   = -1;
        @(posedge clk); #1;
        if (is_if) begin
            if_req = 1'b1; if_addr = addr;
            if_q.push_back(exp);
        end else begin
            mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wdata;
            mem_q.push_back('{!we, exp});
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= n) begin
                checkOutput("ram_addr", ram_addr, addr + 32'(k - 1));
                checkOutput("ram_wr", {31'd0, ram_wr}, {31'd0, we});
                if (we) checkOutput("ram_dout", {24'd0, ram_dout}, {24'd0, wdata[8*(k-1) +: 8]});
            end
            if (is_if ? if_done : mem_done) begin
                t = k;
                break;
            end
        end
        checkOutput("done_latency", 32'(t), 32'(lat));
        @(posedge clk); #1;
        if_req = 1'b0; mem_req = 1'b0;
    endtask

    // Fetch and data requests overlapping; mem_req is raised at cycle mem_at
    task automatic runPair(input int mem_at, input int exp_mem, input int exp_if);
        int t_mem, t_if;
        t_mem = -1; t_if = -1;
        @(posedge clk); #1;
        if_req = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (k == mem_at) mem_req = 1'b1;
            @(negedge clk);
            if (mem_done) t_mem = k;
            if (if_done) t_if = k;
            @(posedge clk); #1;
            if (t_mem == k) mem_req = 1'b0;
            if (t_if == k) if_req = 1'b0;
            if (t_mem >= 0 && t_if >= 0) break;
        end
        checkOutput("pair_mem_cycle", 32'(t_mem), 32'(exp_mem));
        checkOutput("pair_if_cycle", 32'(t_if), 32'(exp_if));
        if_req = 1'b0; mem_req = 1'b0;
    endtask

    initial begin
        int t;
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; ram_init = 1'b1;
        if_req = 1'b0; if_addr = 32'd0; if_flush = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'd0; mem_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; ram_init = 1'b0;
        @(negedge clk);
        checkOutput("reset_if_done", {31'd0, if_done}, 32'd0);
        checkOutput("reset_if_data", if_data, 32'd0);
        checkOutput("reset_mem_rdata", mem_rdata, 32'd0);
        checkOutput("reset_ram_addr", ram_addr, 32'd0);
        checkOutput("reset_ram_wr", {31'd0, ram_wr}, 32'd0);

        applyStimulus(1'b1, 1'b0, 2'b11, 32'h100, 32'd0, 32'h00100513);
        applyStimulus(1'b0, 1'b0, 2'b00, 32'h201, 32'd0, 32'h000000AB);
        applyStimulus(1'b0, 1'b0, 2'b01, 32'h200, 32'd0, 32'h0000AB34);
        applyStimulus(1'b0, 1'b0, 2'b10, 32'h100, 32'd0, 32'h00100513);
        applyStimulus(1'b0, 1'b1, 2'b11, 32'h300, 32'hDEADBEEF, 32'd0);
        checkOutput("store_b0", {24'd0, ram[12'h300]}, 32'hEF);
        checkOutput("store_b1", {24'd0, ram[12'h301]}, 32'hBE);
        checkOutput("store_b2", {24'd0, ram[12'h302]}, 32'hAD);
        checkOutput("store_b3", {24'd0, ram[12'h303]}, 32'hDE);
        applyStimulus(1'b0, 1'b0, 2'b11, 32'h300, 32'd0, 32'hDEADBEEF);
        applyStimulus(1'b0, 1'b0, 2'b11, 32'hFFFFFFFE, 32'd0, 32'h44332211);

        // Simultaneous requests: data first, fetch after DONE plus one idle cycle
        mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h201; if_addr = 32'h100;
        mem_q.push_back('{1'b1, 32'h000000AB}); if_q.push_back(32'h00100513);
        runPair(0, 3, 10);
        // Data request arriving mid-fetch waits for the fetch to finish
        mem_len = 2'b01; mem_addr = 32'h200; if_addr = 32'h104;
        mem_q.push_back('{1'b1, 32'h0000AB34}); if_q.push_back(32'h00000893);
        runPair(2, 11, 6);

        // Flush in cycle 3, branch target fetched from cycle 4
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h100;
        repeat (3) @(posedge clk);
        #1; if_flush = 1'b1; if_addr = 32'h104;
        @(posedge clk); #1;
        if_flush = 1'b0;
        if_q.push_back(32'h00000893);
        @(negedge clk);
        checkOutput("flush_idle_addr", ram_addr, 32'd0);
        t = -1;
        for (int k = 5; k < 30; k++) begin
            @(negedge clk);
            if (if_done) begin
                t = k;
                break;
            end
        end
        checkOutput("flush_refetch_cycle", 32'(t), 32'd10);
        @(posedge clk); #1;
        if_req = 1'b0;

        // Reset during a word store after two bytes have been written
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b11; mem_addr = 32'h400; mem_wdata = 32'h11223344;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_req = 1'b0;
        @(negedge clk);
        checkOutput("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        checkOutput("rst_ram_addr", ram_addr, 32'd0);
        checkOutput("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
        checkOutput("rst_if_data", if_data, 32'd0);
        checkOutput("rst_mem_rdata", mem_rdata, 32'd0);
        for (int k = 0; k < 6; k++) begin
            checkOutput("rst_no_mem_done", {31'd0, mem_done}, 32'd0);
            @(negedge clk);
        end
        checkOutput("rst_store_b0", {24'd0, ram[12'h400]}, 32'h44);
        checkOutput("rst_store_b1", {24'd0, ram[12'h401]}, 32'h33);
        checkOutput("rst_store_b2", {24'd0, ram[12'h402]}, 32'h00);
        checkOutput("rst_store_b3", {24'd0, ram[12'h403]}, 32'h00);
        checkOutput("if_queue_drained", 32'(if_q.size()), 32'd0);
        checkOutput("mem_queue_drained", 32'(mem_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
